// File: rtl/rgb_awb_gain_if.sv
// Pixel stream bundle for rgb_awb_gain: demosaiced input beats and balanced output beats.
// Valid-only stream with no backpressure: a beat transfers on every clock where *_valid is high.
interface rgb_awb_gain_if;
  logic       din_valid;
  logic [7:0] din_r;
  logic [7:0] din_g;
  logic [7:0] din_b;
  logic       dout_valid;
  logic [7:0] dout_r;
  logic [7:0] dout_g;
  logic [7:0] dout_b;

  modport master (
    output din_valid, din_r, din_g, din_b,
    input  dout_valid, dout_r, dout_g, dout_b
  );

  modport slave (
    input  din_valid, din_r, din_g, din_b,
    output dout_valid, dout_r, dout_g, dout_b
  );
endinterface

// File: rtl/rgb_awb_gain.sv
// Gray-world auto white balance on the display clock: per-frame RGB sums, sequential
// R/B gain division between frames, and a 2-stage multiply/saturate pixel pipeline.
module rgb_awb_gain #(
  parameter int SUM_W     = 28,
  parameter int GAIN_W    = 12,
  parameter int GAIN_FRAC = 8
) (
  input  logic              clk_disp,
  input  logic              rst_n,
  input  logic              frame_begin,
  input  logic              awb_en,
  rgb_awb_gain_if.slave     pix,
  output logic [GAIN_W-1:0] gain_r,
  output logic [GAIN_W-1:0] gain_b,
  output logic              gain_busy,
  output logic [1:0]        state_dbg
);

  localparam int DIV_N  = SUM_W + GAIN_FRAC;
  localparam int CNT_W  = $clog2(DIV_N);
  localparam int PROD_W = 8 + GAIN_W;
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(1 << GAIN_FRAC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV_R  = 2'd1,
    DIV_B  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t             state;
  logic [SUM_W-1:0]   sum_r, sum_g, sum_b;
  logic [SUM_W-1:0]   snap_g, snap_b;
  logic [CNT_W-1:0]   cnt;
  logic [SUM_W-1:0]   rem;
  logic [DIV_N-1:0]   dq;
  logic [SUM_W-1:0]   divisor;
  logic [GAIN_W-1:0]  calc_r, calc_b;
  logic [GAIN_W-1:0]  pend_r, pend_b;
  logic               pend_vld;

  assign state_dbg = state;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] s, input logic [7:0] p);
    logic [SUM_W:0] t;
    t = {1'b0, s} + (SUM_W+1)'(p);
    return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
  endfunction

  // Red snapshot is never stored: the red divisor is loaded straight from sum_r at the frame edge.
  always_ff @(posedge clk_disp or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= '0;
      sum_g  <= '0;
      sum_b  <= '0;
      snap_g <= '0;
      snap_b <= '0;
    end else if (frame_begin) begin
      snap_g <= sum_g;
      snap_b <= sum_b;
      sum_r  <= pix.din_valid ? SUM_W'(pix.din_r) : '0;
      sum_g  <= pix.din_valid ? SUM_W'(pix.din_g) : '0;
      sum_b  <= pix.din_valid ? SUM_W'(pix.din_b) : '0;
    end else if (pix.din_valid) begin
      sum_r <= sat_add(sum_r, pix.din_r);
      sum_g <= sat_add(sum_g, pix.din_g);
      sum_b <= sat_add(sum_b, pix.din_b);
    end
  end

  // One restoring-division step; a zero divisor yields all-ones, which saturates to max gain.
  logic [SUM_W:0]    trial;
  logic              fits;
  logic [SUM_W-1:0]  rem_nxt;
  logic [DIV_N-1:0]  q_nxt;
  logic [GAIN_W-1:0] q_sat;

  always_comb begin
    trial   = {rem, dq[DIV_N-1]};
    fits    = (trial >= {1'b0, divisor});
    rem_nxt = fits ? SUM_W'(trial - {1'b0, divisor}) : SUM_W'(trial);
    q_nxt   = {dq[DIV_N-2:0], fits};
    q_sat   = (|q_nxt[DIV_N-1:GAIN_W]) ? {GAIN_W{1'b1}} : q_nxt[GAIN_W-1:0];
  end

  always_ff @(posedge clk_disp or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gain_busy <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      dq        <= '0;
      divisor   <= '0;
      calc_r    <= UNITY;
      calc_b    <= UNITY;
      pend_r    <= UNITY;
      pend_b    <= UNITY;
      pend_vld  <= 1'b0;
      gain_r    <= UNITY;
      gain_b    <= UNITY;
    end else if (frame_begin) begin
      if (pend_vld) begin
        gain_r   <= pend_r;
        gain_b   <= pend_b;
        pend_vld <= 1'b0;
      end
      state     <= DIV_R;
      gain_busy <= 1'b1;
      cnt       <= CNT_LAST;
      rem       <= '0;
      dq        <= {sum_g, {GAIN_FRAC{1'b0}}};
      divisor   <= sum_r;
    end else begin
      case (state)
        IDLE: ;
        DIV_R: begin
          rem <= rem_nxt;
          dq  <= q_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            calc_r  <= q_sat;
            state   <= DIV_B;
            cnt     <= CNT_LAST;
            rem     <= '0;
            dq      <= {snap_g, {GAIN_FRAC{1'b0}}};
            divisor <= snap_b;
          end
        end
        DIV_B: begin
          rem <= rem_nxt;
          dq  <= q_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            calc_b <= q_sat;
            state  <= UPDATE;
          end
        end
        UPDATE: begin
          // A black frame gives no colour information, so fall back to unity.
          pend_r    <= (snap_g == '0) ? UNITY : calc_r;
          pend_b    <= (snap_g == '0) ? UNITY : calc_b;
          pend_vld  <= 1'b1;
          state     <= IDLE;
          gain_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gains loaded on this very frame edge apply to the pixel arriving with it.
  logic [GAIN_W-1:0] gsel_r, gsel_b;

  always_comb begin
    gsel_r = gain_r;
    gsel_b = gain_b;
    if (frame_begin && pend_vld) begin
      gsel_r = pend_r;
      gsel_b = pend_b;
    end
    if (!awb_en) begin
      gsel_r = UNITY;
      gsel_b = UNITY;
    end
  end

  function automatic logic [7:0] sat_px(input logic [PROD_W-1:0] p);
    logic [PROD_W-1:0] s;
    s = p >> GAIN_FRAC;
    return (|s[PROD_W-1:8]) ? 8'hFF : s[7:0];
  endfunction

  logic              v1;
  logic [PROD_W-1:0] prod_r, prod_b;
  logic [7:0]        g1;

  always_ff @(posedge clk_disp or negedge rst_n) begin
    if (!rst_n) begin
      v1             <= 1'b0;
      prod_r         <= '0;
      prod_b         <= '0;
      g1             <= '0;
      pix.dout_valid <= 1'b0;
      pix.dout_r     <= '0;
      pix.dout_g     <= '0;
      pix.dout_b     <= '0;
    end else begin
      v1 <= pix.din_valid;
      if (pix.din_valid) begin
        prod_r <= PROD_W'(pix.din_r) * PROD_W'(gsel_r);
        prod_b <= PROD_W'(pix.din_b) * PROD_W'(gsel_b);
        g1     <= pix.din_g;
      end
      pix.dout_valid <= v1;
      if (v1) begin
        pix.dout_r <= sat_px(prod_r);
        pix.dout_g <= g1;
        pix.dout_b <= sat_px(prod_b);
      end
    end
  end

endmodule

// File: tb/tb_rgb_awb_gain.sv
// Directed bench for rgb_awb_gain: a frame-level gray-world model checked every cycle,
// plus literal expectations taken from hand-worked frames.
module tb_rgb_awb_gain;
  localparam int SUM_W       = 28;
  localparam int GAIN_W      = 12;
  localparam int GAIN_FRAC   = 8;
  localparam int UNITY       = 1 << GAIN_FRAC;
  localparam int GMAX        = (1 << GAIN_W) - 1;
  localparam int BUSY_CYCLES = 2 * (SUM_W + GAIN_FRAC) + 1;
  localparam longint SUM_MAX = (64'd1 << SUM_W) - 1;

  // clock / reset
  logic clk_disp = 1'b0;
  always #5 clk_disp = ~clk_disp;

  logic              rst_n;
  logic              frame_begin;
  logic              awb_en;
  logic [GAIN_W-1:0] gain_r, gain_b;
  logic              gain_busy;
  logic [1:0]        state_dbg;

  rgb_awb_gain_if pif ();

  rgb_awb_gain #(.SUM_W(SUM_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)) dut (
    .clk_disp    (clk_disp),
    .rst_n       (rst_n),
    .frame_begin (frame_begin),
    .awb_en      (awb_en),
    .pix         (pif.slave),
    .gain_r      (gain_r),
    .gain_b      (gain_b),
    .gain_busy   (gain_busy),
    .state_dbg   (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level model
  longint      m_sum_r, m_sum_g, m_sum_b;
  int          m_act_r = UNITY, m_act_b = UNITY;
  int          m_pend_r, m_pend_b, m_fly_r, m_fly_b;
  bit          m_pend_vld = 0;
  int          m_cd = 0;
  bit          m_s1v = 0;
  bit          exp_v = 0;
  logic [23:0] m_hold = '0;
  logic [23:0] exp_q[$];

  function automatic int gain_of(input longint g, input longint d);
    longint q;
    if (g == 0) return UNITY;
    if (d == 0) return GMAX;
    q = (g << GAIN_FRAC) / d;
    return (q > GMAX) ? GMAX : int'(q);
  endfunction

  function automatic int scale(input int p, input int g);
    int v;
    v = (p * g) >> GAIN_FRAC;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic longint sadd(input longint s, input int p);
    return (s + p > SUM_MAX) ? SUM_MAX : s + p;
  endfunction

  task automatic model_step();
    int gr, gb;
    if (!rst_n) begin
      m_sum_r = 0; m_sum_g = 0; m_sum_b = 0;
      m_act_r = UNITY; m_act_b = UNITY;
      m_pend_vld = 0; m_cd = 0; m_s1v = 0; exp_v = 0; m_hold = '0;
      exp_q.delete();
    end else begin
      exp_v = m_s1v;
      if (frame_begin) begin
        if (m_pend_vld) begin
          m_act_r = m_pend_r;
          m_act_b = m_pend_b;
          m_pend_vld = 0;
        end
        m_fly_r = gain_of(m_sum_g, m_sum_r);
        m_fly_b = gain_of(m_sum_g, m_sum_b);
        m_cd    = BUSY_CYCLES;
        m_sum_r = pif.din_valid ? longint'(pif.din_r) : 0;
        m_sum_g = pif.din_valid ? longint'(pif.din_g) : 0;
        m_sum_b = pif.din_valid ? longint'(pif.din_b) : 0;
      end else begin
        if (pif.din_valid) begin
          m_sum_r = sadd(m_sum_r, int'(pif.din_r));
          m_sum_g = sadd(m_sum_g, int'(pif.din_g));
          m_sum_b = sadd(m_sum_b, int'(pif.din_b));
        end
        if (m_cd > 0) begin
          m_cd--;
          if (m_cd == 0) begin
            m_pend_r = m_fly_r;
            m_pend_b = m_fly_b;
            m_pend_vld = 1;
          end
        end
      end
      if (pif.din_valid) begin
        gr = awb_en ? m_act_r : UNITY;
        gb = awb_en ? m_act_b : UNITY;
        exp_q.push_back({8'(scale(int'(pif.din_r), gr)), pif.din_g, 8'(scale(int'(pif.din_b), gb))});
      end
      m_s1v = pif.din_valid;
    end
  endtask

  task automatic compare();
    logic [23:0] e;
    check("gain_r", 32'(gain_r), 32'(m_act_r));
    check("gain_b", 32'(gain_b), 32'(m_act_b));
    check("gain_busy", 32'(gain_busy), 32'(m_cd > 0));
    check("dout_valid", 32'(pif.dout_valid), 32'(exp_v));
    if (exp_v) begin
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("dout_px", {8'h0, pif.dout_r, pif.dout_g, pif.dout_b}, {8'h0, e});
        m_hold = e;
      end
    end else begin
      check("dout_hold", {8'h0, pif.dout_r, pif.dout_g, pif.dout_b}, {8'h0, m_hold});
    end
  endtask

  // scoreboard: update model on the edge, compare just after it
  always begin
    @(posedge clk_disp);
    model_step();
    #1;
    compare();
  end

  // driver tasks: inputs change on the falling edge
  task automatic drive(input bit v, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input bit fb);
    @(negedge clk_disp);
    pif.din_valid = v;
    pif.din_r     = r;
    pif.din_g     = g;
    pif.din_b     = b;
    frame_begin   = fb;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic pulse_fb();
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    idle(1);
  endtask

  task automatic send_frame(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input int n);
    repeat (n) drive(1'b1, r, g, b, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    idle(1);
    while (gain_busy && n < 300) begin
      @(negedge clk_disp);
      n++;
    end
    check("busy_timeout", 32'(gain_busy), 32'd0);
  endtask

  task automatic check_px(input string name, input logic [23:0] exp);
    check({name, "_valid"}, 32'(pif.dout_valid), 32'd1);
    check(name, {8'h0, pif.dout_r, pif.dout_g, pif.dout_b}, {8'h0, exp});
  endtask

  task automatic check_gains(input string name, input int r, input int b);
    check({name, "_r"}, 32'(gain_r), 32'(r));
    check({name, "_b"}, 32'(gain_b), 32'(b));
  endtask

  initial begin
    rst_n = 1'b0; frame_begin = 1'b0; awb_en = 1'b1;
    pif.din_valid = 1'b0; pif.din_r = '0; pif.din_g = '0; pif.din_b = '0;
    repeat (3) @(negedge clk_disp);
    check_gains("rst_gain", 'h100, 'h100);
    check("rst_busy", 32'(gain_busy), 32'd0);
    check("rst_dout_valid", 32'(pif.dout_valid), 32'd0);
    check("rst_dout", {8'h0, pif.dout_r, pif.dout_g, pif.dout_b}, 32'd0);
    rst_n = 1'b1;

    // gray-world gains from a uniform frame, with the frame-edge bypass
    pulse_fb();
    wait_idle();
    send_frame(8'd64, 8'd128, 8'd32, 8);
    pulse_fb();
    wait_idle();
    check_gains("t1_pending_not_active", 'h100, 'h100);
    drive(1'b1, 8'd64, 8'd128, 8'd32, 1'b1);
    idle(1);
    check_gains("t1_gain", 'h200, 'h400);
    idle(1);
    check_px("t1_px", 24'h808080);

    // red saturation
    wait_idle();
    drive(1'b1, 8'd200, 8'd10, 8'd10, 1'b0);
    idle(2);
    check_px("t2_px_sat", 24'hFF0A28);

    // black frame gives unity; zero red with green present gives max gain
    pulse_fb();
    wait_idle();
    pulse_fb();
    wait_idle();
    pulse_fb();
    check_gains("t3_black", 'h100, 'h100);
    wait_idle();
    send_frame(8'd0, 8'd100, 8'd50, 4);
    pulse_fb();
    wait_idle();
    pulse_fb();
    check_gains("t3_zero_red", 'hFFF, 'h200);

    // bypass mode keeps the pixel untouched while gains still update
    wait_idle();
    send_frame(8'd64, 8'd128, 8'd32, 8);
    pulse_fb();
    wait_idle();
    awb_en = 1'b0;
    pulse_fb();
    check_gains("t4_gain", 'h200, 'h400);
    drive(1'b1, 8'd17, 8'd34, 8'd51, 1'b0);
    idle(2);
    check_px("t4_px_bypass", 24'h112233);
    awb_en = 1'b1;

    // a frame edge during division restarts it on the new snapshot
    wait_idle();
    send_frame(8'd10, 8'd20, 8'd40, 4);
    pulse_fb();
    send_frame(8'd100, 8'd50, 8'd25, 4);
    idle(4);
    check("t5_busy_mid_div", 32'(gain_busy), 32'd1);
    pulse_fb();
    wait_idle();
    pulse_fb();
    check_gains("t5_restart", 'h080, 'h200);

    // asynchronous reset while pixels are streaming and a division is running
    wait_idle();
    send_frame(8'd50, 8'd60, 8'd70, 3);
    pulse_fb();
    drive(1'b1, 8'd90, 8'd90, 8'd90, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_dout_valid", 32'(pif.dout_valid), 32'd0);
    check("t6_rst_dout", {8'h0, pif.dout_r, pif.dout_g, pif.dout_b}, 32'd0);
    check_gains("t6_rst_gain", 'h100, 'h100);
    check("t6_rst_busy", 32'(gain_busy), 32'd0);
    idle(2);
    rst_n = 1'b1;
    drive(1'b1, 8'd90, 8'd60, 8'd30, 1'b0);
    idle(2);
    check_px("t6_post_rst_px", 24'h5A3C1E);
    idle(80);
    check_gains("t6_post_rst_gain", 'h100, 'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
